pci_arbiter_rr: RTL and testbench

Parametrised central PCI bus arbiter, successor to the fixed seven-channel arbiter. It sits beside the PCI core in the host-bridge FPGA. It samples the active-low `req_l` lines and issues one-hot active-low `gnt_l`, using either true round-robin or fixed priority. When no master requests, it parks the bus on a configurable channel. An optional grant timeout revokes a grant whose master never starts a transaction.

---
 rtl/pci_arbiter_rr.sv | 227 ++++++++++++++++++++++
 tb/tb_pci_arbiter_rr.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_arbiter_rr.sv
// pci_arbiter_rr: central PCI bus arbiter for the host-bridge FPGA.
// Samples active-low REQ# lines and drives one-hot active-low GNT#, using
// round-robin (FIXED_PRI=0) or lowest-index-wins fixed priority (FIXED_PRI=1).
// The bus is parked on PARK_CHAN when nobody requests.
// Optional feature macro: PCI_ARB_TIMEOUT_EN builds the grant counter that
// revokes a grant whose master never asserts FRAME#, and the grant_timeout pulse.
// Handshake: REQ#/GNT# follow PCI semantics; a master owns the bus once FRAME#
// is sampled low while its GNT# is low, and the bus is idle again when FRAME#
// and IRDY# are both sampled high.
module pci_arbiter_rr #(
  parameter int NCHANS         = 7,
  parameter int CHAN_W         = 3,
  parameter int PARK_CHAN      = 0,
  parameter int FIXED_PRI      = 0,
  parameter int STARTUP_CYCLES = 8,
  parameter int TIMEOUT        = 16
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              wait_for_it,
  input  logic              frame_l,
  input  logic              irdy_l,
  input  logic [NCHANS-1:0] req_l,
  output logic [NCHANS-1:0] gnt_l,
  output logic [CHAN_W-1:0] owner,
  output logic              grant_timeout
);

  // Elaboration-time parameter range checks.
  if (NCHANS < 2 || NCHANS > 16) begin : g_bad_nchans
    $error("pci_arbiter_rr: NCHANS must be 2..16");
  end
  if ((2 ** CHAN_W) < NCHANS) begin : g_bad_chan_w
    $error("pci_arbiter_rr: CHAN_W too narrow for NCHANS");
  end
  if (PARK_CHAN < 0 || PARK_CHAN >= NCHANS) begin : g_bad_park
    $error("pci_arbiter_rr: PARK_CHAN out of range");
  end
  if (STARTUP_CYCLES < 1 || STARTUP_CYCLES > 255) begin : g_bad_startup
    $error("pci_arbiter_rr: STARTUP_CYCLES must be 1..255");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("pci_arbiter_rr: TIMEOUT must be 2..255");
  end

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_PARK  = 3'd1,
    S_GRANT = 3'd2,
    S_BUSY  = 3'd3,
    S_CHECK = 3'd4
  } state_e;

  localparam logic [NCHANS-1:0] ALL_OFF   = '1;
  localparam logic [NCHANS-1:0] ONE_HOT_0 = NCHANS'(1);
  localparam logic [NCHANS-1:0] PARK_GNT  = ~(ONE_HOT_0 << PARK_CHAN);
  localparam logic [CHAN_W-1:0] PARK_IDX  = CHAN_W'(PARK_CHAN);
  localparam logic [7:0]        START_END = 8'(STARTUP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [NCHANS-1:0]   gnt_q, gnt_d;
  logic [CHAN_W-1:0]   owner_q, owner_d;
  logic [7:0]          start_cnt_q, start_cnt_d;

  logic                win_vld;
  logic [CHAN_W-1:0]   win_idx;
  logic                owner_req_l;

`ifdef PCI_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_END = 8'(TIMEOUT - 1);
  logic [7:0] gcnt_q, gcnt_d;
  logic       gto_q, gto_d;
`endif

  // Arbitration: pick the winning requester from req_l and the last owner.
  // Scanning candidates from the far end and overwriting leaves the first hit.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    if (FIXED_PRI != 0) begin
      for (int i = NCHANS - 1; i >= 0; i--) begin
        if (!req_l[i]) begin
          win_vld = 1'b1;
          win_idx = CHAN_W'(i);
        end
      end
    end else begin
      // Candidates owner+1 .. owner+NCHANS (mod NCHANS); the owner comes last.
      for (int i = NCHANS; i >= 1; i--) begin
        idx = int'(owner_q) + i;
        if (idx >= NCHANS) idx = idx - NCHANS;
        for (int j = 0; j < NCHANS; j++) begin
          if (j == idx && !req_l[j]) begin
            win_vld = 1'b1;
            win_idx = CHAN_W'(j);
          end
        end
      end
    end
  end

  // REQ# of the current owner, used to detect a withdrawn request.
  always_comb begin
    owner_req_l = 1'b1;
    for (int j = 0; j < NCHANS; j++) begin
      if (CHAN_W'(j) == owner_q) owner_req_l = req_l[j];
    end
  end

  // Next-state and next-output logic of the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    start_cnt_d = start_cnt_q;
`ifdef PCI_ARB_TIMEOUT_EN
    gcnt_d      = gcnt_q;
    gto_d       = 1'b0;
`endif
    case (state_q)
      S_RESET: begin
        gnt_d = ALL_OFF;
        if (wait_for_it) begin
          if (start_cnt_q == START_END) begin
            gnt_d       = PARK_GNT;
            start_cnt_d = '0;
            state_d     = S_PARK;
          end else begin
            start_cnt_d = start_cnt_q + 8'd1;
          end
        end
      end
      S_PARK: begin
        if (!frame_l) begin
          // Parked master already started a transaction.
          owner_d = PARK_IDX;
          state_d = S_BUSY;
        end else if (win_vld) begin
          gnt_d   = ~(ONE_HOT_0 << win_idx);
          owner_d = win_idx;
          state_d = S_GRANT;
`ifdef PCI_ARB_TIMEOUT_EN
          gcnt_d  = '0;
`endif
        end else begin
          gnt_d = PARK_GNT;
        end
      end
      S_GRANT: begin
        if (!frame_l) begin
          state_d = S_BUSY;
        end else if (owner_req_l) begin
          gnt_d   = ALL_OFF;
          state_d = S_CHECK;
`ifdef PCI_ARB_TIMEOUT_EN
        end else if (gcnt_q == TO_END) begin
          gnt_d   = ALL_OFF;
          gto_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          gcnt_d  = gcnt_q + 8'd1;
`endif
        end
      end
      S_BUSY: begin
        // Grant drops one cycle after FRAME# was seen.
        gnt_d = ALL_OFF;
        if (frame_l && irdy_l) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (win_vld) begin
          gnt_d   = ~(ONE_HOT_0 << win_idx);
          owner_d = win_idx;
          state_d = S_GRANT;
`ifdef PCI_ARB_TIMEOUT_EN
          gcnt_d  = '0;
`endif
        end else begin
          gnt_d   = PARK_GNT;
          state_d = S_PARK;
        end
      end
      default: begin
        gnt_d   = ALL_OFF;
        state_d = S_RESET;
      end
    endcase
  end

  // FSM state, grant, owner and startup counter registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= S_RESET;
      gnt_q       <= ALL_OFF;
      owner_q     <= '0;
      start_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      start_cnt_q <= start_cnt_d;
    end
  end

`ifdef PCI_ARB_TIMEOUT_EN
  // Grant counter and timeout pulse registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      gcnt_q <= '0;
      gto_q  <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      gto_q  <= gto_d;
    end
  end

  assign grant_timeout = gto_q;
`else
  assign grant_timeout = 1'b0;
`endif

  assign gnt_l = gnt_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_pci_arbiter_rr.sv
// Directed testbench for pci_arbiter_rr: one round-robin and one
// fixed-priority instance share clock, reset, FRAME#/IRDY# and wait_for_it.
// Timeout checks are compiled in when PCI_ARB_TIMEOUT_EN is defined.
module tb_pci_arbiter_rr;
  localparam int N = 7;
  localparam logic [N-1:0] ALL = 7'h7f;

  logic         clk = 1'b0;
  logic         reset_l, wait_for_it, frame_l, irdy_l;
  logic [N-1:0] req_rr, req_fp, gnt_rr, gnt_fp;
  logic [2:0]   own_rr, own_fp;
  logic         gto_rr, gto_fp;

  int tests = 0;
  int fails = 0;
  int exp_rr[6] = '{1, 4, 6, 1, 4, 6};

  // Clock
  always #5 clk = ~clk;

  pci_arbiter_rr #(
    .NCHANS(7), .CHAN_W(3), .PARK_CHAN(0), .FIXED_PRI(0),
    .STARTUP_CYCLES(8), .TIMEOUT(16)
  ) dut_rr (
    .clk(clk), .reset_l(reset_l), .wait_for_it(wait_for_it),
    .frame_l(frame_l), .irdy_l(irdy_l), .req_l(req_rr),
    .gnt_l(gnt_rr), .owner(own_rr), .grant_timeout(gto_rr)
  );

  pci_arbiter_rr #(
    .NCHANS(7), .CHAN_W(3), .PARK_CHAN(0), .FIXED_PRI(1),
    .STARTUP_CYCLES(8), .TIMEOUT(16)
  ) dut_fp (
    .clk(clk), .reset_l(reset_l), .wait_for_it(wait_for_it),
    .frame_l(frame_l), .irdy_l(irdy_l), .req_l(req_fp),
    .gnt_l(gnt_fp), .owner(own_fp), .grant_timeout(gto_fp)
  );

  function automatic logic [N-1:0] g(input int ch);
    logic [N-1:0] one;
    one = 7'd1;
    return ~(one << ch);
  endfunction

  task automatic chk_g(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s gnt_l observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s owner observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s grant_timeout observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are looked at 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction by the granted master: FRAME#/IRDY# low 2 cycles, then idle.
  task automatic txn(input bit fp, input int ch);
    frame_l = 1'b0; irdy_l = 1'b0;
    step();
    chk_g("txn_hold", fp ? gnt_fp : gnt_rr, g(ch));
    step();
    chk_g("txn_busy_off", fp ? gnt_fp : gnt_rr, ALL);
    frame_l = 1'b1; irdy_l = 1'b1;
    step();
    chk_g("txn_check_off", fp ? gnt_fp : gnt_rr, ALL);
  endtask

  initial begin
    // Reset
    reset_l = 1'b0; wait_for_it = 1'b0; frame_l = 1'b1; irdy_l = 1'b1;
    req_rr = ALL; req_fp = ALL;
    repeat (2) @(posedge clk);
    #1;
    chk_g("reset_gnt", gnt_rr, ALL);
    chk_o("reset_owner", own_rr, 3'd0);
    chk_b("reset_gto", gto_rr, 1'b0);
    chk_g("reset_gnt_fp", gnt_fp, ALL);

    // Startup: 4 qualified, 3 unqualified, 4 qualified cycles
    reset_l = 1'b1; wait_for_it = 1'b1;
    repeat (4) step();
    chk_g("startup_4", gnt_rr, ALL);
    wait_for_it = 1'b0;
    repeat (3) step();
    chk_g("startup_gap", gnt_rr, ALL);
    wait_for_it = 1'b1;
    repeat (3) step();
    chk_g("startup_7", gnt_rr, ALL);
    step();
    chk_g("startup_park", gnt_rr, 7'b1111110);
    chk_g("startup_park_fp", gnt_fp, 7'b1111110);

    // Parked master runs a transaction
    txn(1'b0, 0);
    chk_o("park_busy_owner", own_rr, 3'd0);
    step();
    chk_g("park_return", gnt_rr, g(0));

    // Round-robin among ch1, ch4, ch6
    req_rr = 7'b0101101;
    step();
    for (int k = 0; k < 6; k++) begin
      chk_g("rr_grant", gnt_rr, g(exp_rr[k]));
      chk_o("rr_owner", own_rr, 3'(exp_rr[k]));
      txn(1'b0, exp_rr[k]);
      step();
    end
    chk_g("rr_grant_7", gnt_rr, g(1));
    req_rr = ALL;
    step();
    chk_g("rr_withdraw_off", gnt_rr, ALL);
    step();
    chk_g("rr_park", gnt_rr, g(0));

    // ch2 granted then withdraws
    req_rr = 7'b1111011;
    step();
    chk_g("wd_grant2", gnt_rr, g(2));
    chk_o("wd_owner2", own_rr, 3'd2);
    req_rr = ALL;
    step();
    chk_g("wd_check", gnt_rr, ALL);
    step();
    chk_g("wd_park", gnt_rr, g(0));

    // ch3 never starts; ch1 also waiting
    req_rr = 7'b1110101;
    step();
    chk_g("to_grant3", gnt_rr, g(3));
`ifdef PCI_ARB_TIMEOUT_EN
    for (int k = 2; k <= 16; k++) begin
      step();
      chk_g("to_hold", gnt_rr, g(3));
      chk_b("to_no_pulse", gto_rr, 1'b0);
    end
    step();
    chk_g("to_revoke", gnt_rr, ALL);
    chk_b("to_pulse", gto_rr, 1'b1);
    step();
    chk_b("to_pulse_end", gto_rr, 1'b0);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk_g("nto_hold", gnt_rr, g(3));
      chk_b("nto_gto_zero", gto_rr, 1'b0);
    end
    req_rr = 7'b1111101;
    step();
    chk_g("nto_withdraw", gnt_rr, ALL);
    step();
`endif
    chk_g("after3_grant1", gnt_rr, g(1));
    chk_o("after3_owner1", own_rr, 3'd1);
    req_rr = ALL;
    step();
    chk_g("after3_check", gnt_rr, ALL);
    step();
    chk_g("after3_park", gnt_rr, g(0));

`ifdef PCI_ARB_TIMEOUT_EN
    // FRAME# on the cycle the timeout would expire
    req_rr = 7'b1110111;
    step();
    chk_g("co_grant3", gnt_rr, g(3));
    repeat (15) step();
    frame_l = 1'b0; irdy_l = 1'b0;
    step();
    chk_g("co_busy_hold", gnt_rr, g(3));
    chk_b("co_no_pulse", gto_rr, 1'b0);
    step();
    chk_g("co_busy_off", gnt_rr, ALL);
    chk_b("co_no_pulse2", gto_rr, 1'b0);
    req_rr = ALL; frame_l = 1'b1; irdy_l = 1'b1;
    step();
    chk_g("co_check", gnt_rr, ALL);
    step();
    chk_g("co_park", gnt_rr, g(0));
`endif

    // FRAME# and withdrawal together: FRAME# wins
    req_rr = 7'b1110111;
    step();
    chk_g("fw_grant3", gnt_rr, g(3));
    req_rr = ALL; frame_l = 1'b0; irdy_l = 1'b0;
    step();
    chk_g("fw_busy_hold", gnt_rr, g(3));
    step();
    chk_g("fw_busy_off", gnt_rr, ALL);
    frame_l = 1'b1; irdy_l = 1'b1;
    step();
    chk_g("fw_check", gnt_rr, ALL);
    step();
    chk_g("fw_park", gnt_rr, g(0));

    // Reset in the middle of a BUSY transaction
    req_rr = 7'b1101111;
    step();
    chk_g("rb_grant4", gnt_rr, g(4));
    chk_o("rb_owner4", own_rr, 3'd4);
    frame_l = 1'b0; irdy_l = 1'b0;
    step();
    chk_g("rb_busy_hold", gnt_rr, g(4));
    #2;
    reset_l = 1'b0;
    #1;
    chk_g("rb_async_gnt", gnt_rr, ALL);
    chk_o("rb_async_owner", own_rr, 3'd0);
    #2;
    reset_l = 1'b1; frame_l = 1'b1; irdy_l = 1'b1; req_rr = ALL;
    repeat (7) step();
    chk_g("rb_startup_7", gnt_rr, ALL);
    step();
    chk_g("rb_startup_park", gnt_rr, g(0));
    chk_g("rb_startup_park_fp", gnt_fp, g(0));

    // Fixed priority: ch2 and ch5 both request
    req_fp = 7'b1011011;
    step();
    chk_g("fp_grant2_a", gnt_fp, g(2));
    chk_o("fp_owner2", own_fp, 3'd2);
    txn(1'b1, 2);
    step();
    chk_g("fp_grant2_b", gnt_fp, g(2));
    txn(1'b1, 2);
    step();
    chk_g("fp_grant2_c", gnt_fp, g(2));
    req_fp = 7'b1011111;
    step();
    chk_g("fp_withdraw2", gnt_fp, ALL);
    step();
    chk_g("fp_grant5", gnt_fp, g(5));
    chk_o("fp_owner5", own_fp, 3'd5);
    txn(1'b1, 5);
    req_fp = ALL;
    step();
    chk_g("fp_park", gnt_fp, g(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
